// File: rtl/alu_pkg.sv
// Shared opcode values, one-hot bit positions and sequencer state type.
// Build option: ALU_OPSEQ_MULDIV_EN enables the multi-cycle MULT/DIV state.
package alu_pkg;

  localparam int unsigned ONEHOT_W = 8;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_SLL  = 4;
  localparam int unsigned OP_SRA  = 5;
  localparam int unsigned OP_MULT = 6;
  localparam int unsigned OP_DIV  = 7;

  localparam int unsigned BIT_ADD  = 0;
  localparam int unsigned BIT_SUB  = 1;
  localparam int unsigned BIT_AND  = 2;
  localparam int unsigned BIT_OR   = 3;
  localparam int unsigned BIT_SLL  = 4;
  localparam int unsigned BIT_SRA  = 5;
  localparam int unsigned BIT_MULT = 6;
  localparam int unsigned BIT_DIV  = 7;

  typedef enum logic [1:0] {
    IDLE
    , HOLD
`ifdef ALU_OPSEQ_MULDIV_EN
    , MC_BUSY
`endif
  } state_t;

endpackage

// File: rtl/alu_opcode_onehot.sv
// Combinational opcode decoder: OPW-bit opcode to 8-bit one-hot plus illegal flag.
// Build option: ALU_OPSEQ_MULDIV_EN makes opcodes 6/7 legal (MULT/DIV).
module alu_opcode_onehot
  import alu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0]      opcode,
  output logic [ONEHOT_W-1:0] op_c,
  output logic                illegal_c
);

  always_comb begin
    op_c      = '0;
    illegal_c = 1'b0;
    case (32'(opcode))
      OP_ADD:  op_c[3'(BIT_ADD)] = 1'b1;
      OP_SUB:  op_c[3'(BIT_SUB)] = 1'b1;
      OP_AND:  op_c[3'(BIT_AND)] = 1'b1;
      OP_OR:   op_c[3'(BIT_OR)]  = 1'b1;
      OP_SLL:  op_c[3'(BIT_SLL)] = 1'b1;
      OP_SRA:  op_c[3'(BIT_SRA)] = 1'b1;
`ifdef ALU_OPSEQ_MULDIV_EN
      OP_MULT: op_c[3'(BIT_MULT)] = 1'b1;
      OP_DIV:  op_c[3'(BIT_DIV)]  = 1'b1;
`endif
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_opcode_seq.sv
// Opcode sequencer: accepts opcodes, holds a one-hot decoded result until consumed.
// Build option: ALU_OPSEQ_MULDIV_EN enables multi-cycle MULT/DIV with a busy phase.
module alu_opcode_seq
  import alu_pkg::*;
#(
  parameter int unsigned OPW       = 5,
  parameter int unsigned MC_CYCLES = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] ctrl_opcode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_op,
  output logic           out_illegal,
  output logic           busy,
  input  logic           err_clr,
  output logic           err_sticky
);

  if (OPW < 3 || OPW > 8) begin : g_bad_opw
    $error("alu_opcode_seq: OPW out of range 3..8");
  end
  if (MC_CYCLES < 2 || MC_CYCLES > 255) begin : g_bad_mc
    $error("alu_opcode_seq: MC_CYCLES out of range 2..255");
  end

  state_t                state;
  logic [ONEHOT_W-1:0]   dec_op;
  logic                  dec_illegal;
  logic                  xfer;

  alu_opcode_onehot #(.OPW(OPW)) u_dec (
    .opcode    (ctrl_opcode),
    .op_c      (dec_op),
    .illegal_c (dec_illegal)
  );

  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign xfer     = in_valid & in_ready;

`ifdef ALU_OPSEQ_MULDIV_EN
  localparam int unsigned CNTW = $clog2(MC_CYCLES);
  logic [CNTW-1:0] mc_cnt;
  logic            mc_div;
  logic            dec_multi;
  assign dec_multi = |dec_op[7:6];
`else
  assign busy = 1'b0;
`endif

  // Single-process FSM; HOLD accepts a new opcode in the same cycle it is drained.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_illegal <= 1'b0;
      err_sticky  <= 1'b0;
`ifdef ALU_OPSEQ_MULDIV_EN
      busy        <= 1'b0;
      mc_cnt      <= '0;
      mc_div      <= 1'b0;
`endif
    end else begin
      if (xfer && dec_illegal) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end

      case (state)
        IDLE, HOLD: begin
          if (xfer) begin
`ifdef ALU_OPSEQ_MULDIV_EN
            if (dec_multi) begin
              state       <= MC_BUSY;
              mc_cnt      <= CNTW'(MC_CYCLES - 1);
              mc_div      <= dec_op[3'(BIT_DIV)];
              busy        <= 1'b1;
              out_valid   <= 1'b0;
              out_op      <= '0;
              out_illegal <= 1'b0;
            end else
`endif
            begin
              state       <= HOLD;
              out_valid   <= 1'b1;
              out_op      <= dec_op;
              out_illegal <= dec_illegal;
            end
          end else if ((state == HOLD) && out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_illegal <= 1'b0;
          end
        end
`ifdef ALU_OPSEQ_MULDIV_EN
        MC_BUSY: begin
          if (mc_cnt == '0) begin
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_op    <= mc_div ? (8'(1) << BIT_DIV) : (8'(1) << BIT_MULT);
          end else begin
            mc_cnt <= mc_cnt - CNTW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_opcode_seq.sv
// Self-checking bench for alu_opcode_seq against a transaction-level reference model.
// Honours ALU_OPSEQ_MULDIV_EN the same way as the design build.
module tb_alu_opcode_seq;

  localparam int MC = 4;
`ifdef ALU_OPSEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] ctrl_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_op;
  logic       out_illegal;
  logic       busy;
  logic       err_clr;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  // Reference model: pending result, remaining busy cycles, sticky error.
  bit       m_valid;
  bit [7:0] m_op;
  bit       m_ill;
  int       m_busy_left;
  bit [7:0] m_pend;
  bit       m_err;

  alu_opcode_seq #(.OPW(5), .MC_CYCLES(MC)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ctrl_opcode (ctrl_opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_illegal (out_illegal),
    .busy        (busy),
    .err_clr     (err_clr),
    .err_sticky  (err_sticky)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_op = '0; m_ill = 0; m_busy_left = 0; m_pend = '0; m_err = 0;
  endtask

  function automatic bit exp_ready(input bit ordy);
    return (m_busy_left == 0) && (!m_valid || ordy);
  endfunction

  task automatic check_outputs(input bit ordy);
    chk("in_ready",    32'(in_ready),    32'(exp_ready(ordy)));
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("out_op",      32'(out_op),      32'(m_op));
    chk("out_illegal", 32'(out_illegal), 32'(m_ill));
    chk("busy",        32'(busy),        32'(m_busy_left > 0));
    chk("err_sticky",  32'(err_sticky),  32'(m_err));
  endtask

  task automatic model_step(input bit iv, input logic [4:0] op, input bit ordy, input bit clr);
    int  code;
    bit  xfer, multi, ill;
    code  = int'(op);
    xfer  = iv && exp_ready(ordy);
    multi = MD_EN && (code == 6 || code == 7);
    ill   = (code > 7) || (!MD_EN && code >= 6);
    if (xfer && ill) m_err = 1;
    else if (clr)    m_err = 0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_valid = 1; m_op = m_pend; m_ill = 0;
      end
    end else if (xfer) begin
      if (multi) begin
        m_busy_left = MC; m_pend = 8'(1 << code);
        m_valid = 0; m_op = '0; m_ill = 0;
      end else begin
        m_valid = 1; m_ill = ill; m_op = ill ? 8'h00 : 8'(1 << code);
      end
    end else if (m_valid && ordy) begin
      m_valid = 0; m_op = '0; m_ill = 0;
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model.
  task automatic cycle(input bit iv, input logic [4:0] op, input bit ordy, input bit clr);
    @(negedge clock);
    in_valid = iv; ctrl_opcode = op; out_ready = ordy; err_clr = clr;
    #1;
    check_outputs(ordy);
    model_step(iv, op, ordy, clr);
  endtask

  task automatic rst_pulse();
    @(negedge clock);
    in_valid = 0; out_ready = 0; err_clr = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [4:0] op;
    reset = 1'b1; in_valid = 0; ctrl_opcode = '0; out_ready = 0; err_clr = 0;
    model_reset();
    @(negedge clock); #1;
    check_outputs(1'b0);
    @(posedge clock); #1 reset = 1'b0;

    // Single-cycle decode, then drain
    cycle(1, 5'h03, 1, 0);
    cycle(1, 5'h00, 1, 0);
    cycle(1, 5'h05, 1, 0);
    cycle(0, 5'h00, 1, 0);

    // Multi-cycle op with in_valid held high throughout
    cycle(1, 5'h06, 1, 0);
    repeat (6) cycle(1, 5'h02, 1, 0);
    cycle(0, 5'h00, 1, 0);

    // Illegal opcode, clear colliding with a new illegal, then a plain clear
    cycle(1, 5'h11, 1, 0);
    cycle(1, 5'h1f, 1, 1);
    cycle(0, 5'h00, 1, 1);
    cycle(0, 5'h00, 1, 0);

    // Stall in HOLD, then back-to-back replacement
    cycle(1, 5'h01, 0, 0);
    repeat (3) cycle(0, 5'h00, 0, 0);
    cycle(1, 5'h04, 1, 0);
    cycle(0, 5'h00, 1, 0);

    // Opcode 7: DIV when enabled, illegal otherwise
    cycle(1, 5'h07, 1, 0);
    repeat (6) cycle(0, 5'h00, 1, 0);

    // Reset during busy / hold
    cycle(1, 5'h06, 0, 0);
    cycle(0, 5'h00, 0, 0);
    rst_pulse();
    cycle(1, 5'h02, 0, 0);
    rst_pulse();
    cycle(0, 5'h00, 1, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_pulse();
      end else begin
        op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0);
      end
    end
    cycle(0, 5'h00, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
